// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage datapath: load-use bubbles, memory-wait
// freeze, branch flush and memory-timeout halt, with saturating stall/flush counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; memory stall, branch flush, load-use evaluated
// MEM_WAIT | data access outstanding; pipe frozen until mem_ready
// HALT     | memory timeout; pipe frozen, mem_err set, left only by reset
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [4:0]       id_addrRs,
   input  logic [4:0]       id_addrRt,
   input  logic             id_usesRt,
   input  logic             ex_memRead,
   input  logic [4:0]       ex_addrRt,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_write,
   output logic             memwb_bubble,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       freeze;
   logic       load_use;

   always_comb begin
      load_use = ex_memRead && (ex_addrRt != 5'd0) &&
                 ((ex_addrRt == id_addrRs) || (id_usesRt && (ex_addrRt == id_addrRt)));
      freeze   = (state == HALT) ||
                 ((state == MEM_WAIT) && !mem_ready) ||
                 ((state == RUN) && mem_req && !mem_ready);
   end

   // The release cycle of a memory wait is evaluated like RUN, so a branch held in EX acts there.
   always_comb begin
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_write  = 1'b1;
      memwb_bubble = 1'b0;
      if (reset_n) begin
         if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
         end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               if (mem_req && !mem_ready) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state    <= RUN;
                  wait_cnt <= 8'd0;
               end else if (wait_cnt == TIMEOUT) begin
                  state   <= HALT;
                  mem_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            HALT:    state <= HALT;
            default: state <= RUN;
         endcase
         if (!pc_write && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (ifid_flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, 4-bit counters so saturation is reachable).
module tb_pipe_hazard_ctrl;

   localparam int CNT_W = 4;

   // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble}
   localparam logic [6:0] DEF = 7'b1101010;
   localparam logic [6:0] FRZ = 7'b0000001;
   localparam logic [6:0] FLS = 7'b1111110;
   localparam logic [6:0] LDU = 7'b0001110;

   logic             clock = 1'b0;
   logic             reset_n;
   logic [4:0]       id_addrRs, id_addrRt, ex_addrRt;
   logic             id_usesRt, ex_memRead, branch_taken, mem_req, mem_ready;
   logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
   logic             exmem_write, memwb_bubble, mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0]       outs;

   int vectors = 0;
   int miscompares = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n),
      .id_addrRs(id_addrRs), .id_addrRt(id_addrRt), .id_usesRt(id_usesRt),
      .ex_memRead(ex_memRead), .ex_addrRt(ex_addrRt), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
      .memwb_bubble(memwb_bubble), .mem_err(mem_err),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clock = ~clock;

   assign outs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      id_addrRs = 5'd0; id_addrRt = 5'd0; id_usesRt = 1'b0;
      ex_memRead = 1'b0; ex_addrRt = 5'd0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      idle();
      #1;
      chk("reset_outs", 32'(outs), 32'(DEF));
      tick(); tick();
      chk("reset_stall", 32'(stall_cnt), 0);
      chk("reset_flush", 32'(flush_cnt), 0);
      chk("reset_err", 32'(mem_err), 0);
      reset_n = 1'b1;
      #1 chk("idle_outs", 32'(outs), 32'(DEF));
      tick();

      // load-use on Rs
      ex_memRead = 1'b1; ex_addrRt = 5'd8; id_addrRs = 5'd8;
      #1 chk("lu_rs", 32'(outs), 32'(LDU));
      tick();
      chk("lu_stall1", 32'(stall_cnt), 1);
      ex_memRead = 1'b0;
      #1 chk("lu_one_bubble", 32'(outs), 32'(DEF));
      tick();
      // register 0 never hazards
      ex_memRead = 1'b1; ex_addrRt = 5'd0; id_addrRs = 5'd0;
      #1 chk("lu_r0", 32'(outs), 32'(DEF));
      tick();
      chk("lu_r0_stall", 32'(stall_cnt), 1);
      // Rt match only counts when Rt is a source
      ex_addrRt = 5'd8; id_addrRs = 5'd3; id_addrRt = 5'd8; id_usesRt = 1'b0;
      #1 chk("lu_rt_unused", 32'(outs), 32'(DEF));
      tick();
      id_usesRt = 1'b1;
      #1 chk("lu_rt_used", 32'(outs), 32'(LDU));
      tick();
      chk("lu_stall2", 32'(stall_cnt), 2);
      idle();

      // memory stall: 3 frozen cycles, advance on the 4th
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("mem_frz%0d", i), 32'(outs), 32'(FRZ));
         tick();
      end
      mem_ready = 1'b1;
      #1 chk("mem_release", 32'(outs), 32'(DEF));
      tick();
      chk("mem_stall_cnt", 32'(stall_cnt), 5);
      idle();

      // branch beats load-use in the same cycle
      branch_taken = 1'b1; ex_memRead = 1'b1; ex_addrRt = 5'd8; id_addrRs = 5'd8;
      #1 chk("br_vs_lu", 32'(outs), 32'(FLS));
      tick();
      chk("br_flush_cnt", 32'(flush_cnt), 1);
      chk("br_stall_cnt", 32'(stall_cnt), 5);
      idle();

      // branch held through a memory stall acts on the release cycle
      branch_taken = 1'b1; mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk($sformatf("brmem_frz%0d", i), 32'(outs), 32'(FRZ));
         tick();
      end
      chk("brmem_noflush", 32'(flush_cnt), 1);
      mem_ready = 1'b1;
      #1 chk("brmem_release", 32'(outs), 32'(FLS));
      tick();
      chk("brmem_flush_cnt", 32'(flush_cnt), 2);
      chk("brmem_stall_cnt", 32'(stall_cnt), 8);
      idle();

      // reset in the middle of MEM_WAIT
      mem_req = 1'b1;
      tick(); tick();
      reset_n = 1'b0;
      #1 chk("rst_wait_outs", 32'(outs), 32'(DEF));
      tick(); tick();
      chk("rst_wait_stall", 32'(stall_cnt), 0);
      chk("rst_wait_flush", 32'(flush_cnt), 0);
      reset_n = 1'b1; mem_req = 1'b0;
      #1 chk("rst_wait_run", 32'(outs), 32'(DEF));
      tick();

      // timeout: entry cycle plus 4 wait cycles, then HALT
      mem_req = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("to_not_yet", 32'(mem_err), 0);
      #1 chk("to_wait_frz", 32'(outs), 32'(FRZ));
      tick();
      chk("to_err", 32'(mem_err), 1);
      chk("to_stall5", 32'(stall_cnt), 5);
      mem_req = 1'b0; mem_ready = 1'b1;
      #1 chk("halt_frz", 32'(outs), 32'(FRZ));
      for (int i = 0; i < 14; i++) tick();
      chk("halt_stall_sat", 32'(stall_cnt), 15);
      chk("halt_err_sticky", 32'(mem_err), 1);
      #1 chk("halt_still_frz", 32'(outs), 32'(FRZ));
      reset_n = 1'b0;
      tick();
      chk("halt_rst_err", 32'(mem_err), 0);
      reset_n = 1'b1; idle();
      #1 chk("halt_rst_run", 32'(outs), 32'(DEF));
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage datapath; owns write-enable and bubble control of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, freezes the pipe on multi-cycle memory accesses, flushes on taken branches, and halts on memory timeout.
- Sits beside the ID stage; reads ID-stage register addresses plus the ID/EX control bundle and drives stage enables.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before the controller halts; legal range 1..255.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  synchronous reset, active low
- id_addrRs  in  5  Rs field of the instruction in ID
- id_addrRt  in  5  Rt field of the instruction in ID
- id_usesRt  in  1  instruction in ID reads Rt as a source
- ex_memRead  in  1  memread bit (M[0]) of the instruction in EX
- ex_addrRt  in  5  Rt address of the instruction in EX (load destination)
- branch_taken  in  1  taken branch/jump resolved in EX this cycle
- mem_req  in  1  MEM stage is issuing a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  ID/EX loads zero WB/M/EX control
- exmem_write  out  1  EX/MEM load enable
- memwb_bubble  out  1  MEM/WB loads zero WB control
- mem_err  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- States: RUN, MEM_WAIT, HALT. State, wait counter (8 bit), mem_err, stall_cnt and flush_cnt are registered; enable/bubble outputs are combinational from state and current inputs.
- Reset (reset_n=0 at posedge): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. While reset_n=0 the outputs read pc_write=ifid_write=idex_write=exmem_write=1, all flush/bubble outputs=0. Reset mid-MEM_WAIT or in HALT returns to RUN on that edge.
- Default (no event, RUN): all write enables 1, all flush/bubble 0.
- Priority, highest first: HALT > memory stall > branch flush > load-use stall.
- Memory stall: in RUN with mem_req=1 and mem_ready=0 -> pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, go to MEM_WAIT, wait counter=1. In MEM_WAIT the same outputs hold. mem_ready=1 -> outputs default this cycle (access completes, pipe advances), go to RUN, counter=0. mem_req=1 with mem_ready=1 in RUN is zero-stall.
- Timeout: in MEM_WAIT with mem_ready=0 and counter==MEM_TIMEOUT -> go to HALT, set mem_err. HALT: all write enables 0, memwb_bubble=1, leave only by reset.
- Branch flush: in RUN, no memory stall, branch_taken=1 -> ifid_flush=1, idex_bubble=1, all write enables 1; flush_cnt++ once per cycle asserted. A branch arriving during a memory stall is held in EX by the freeze and is acted on in the cycle the stall releases.
- Load-use: in RUN, no memory stall or branch, ex_memRead=1, ex_addrRt!=0 and (ex_addrRt==id_addrRs or (id_usesRt=1 and ex_addrRt==id_addrRt)) -> pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1, exmem_write=1. Exactly one bubble per load; register 0 never hazards.
- stall_cnt increments on every cycle where pc_write=0 (load-use, MEM_WAIT, HALT, and the entry cycle of a memory stall); both counters saturate at all-ones, never wrap.

Test Plan:
- Reset: reset_n=0 for 2 cycles mid-MEM_WAIT -> state RUN, counters 0, mem_err=0, enables 1 on the following cycle.
- Load-use: ex_memRead=1, ex_addrRt=8, id_addrRs=8 -> one cycle pc_write=0, ifid_write=0, idex_bubble=1; repeat with ex_addrRt=0 -> no stall; id_addrRt=8 with id_usesRt=0 -> no stall; stall_cnt=1.
- Memory stall: mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 frozen cycles with memwb_bubble=1, advance on 4th, stall_cnt=3.
- Branch vs load-use same cycle: branch_taken=1 plus load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1, flush_cnt=1, stall_cnt unchanged.
- Branch during memory stall: branch_taken=1 held through 2 wait cycles -> no flush until mem_ready cycle, flush in that same release cycle; flush_cnt=1.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 -> HALT entered after 4 wait cycles, mem_err=1 and pipe frozen until reset_n=0.
